meas_bcd_formatter: RTL and testbench

//  Converts the binary measurement word from the frequency/period meter into packed BCD

---
 rtl/meas_fmt_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/meas_bcd_formatter.sv | 174 +++++++++++++++++
 tb/tb_meas_bcd_formatter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/meas_fmt_pkg.sv
// ---------------------------------------------------------------------------
// meas_fmt_pkg
//   Shared types and constants for the measurement BCD formatter.
//   - fmt_state_t   : converter FSM states (IDLE / SHIFT / LOAD_OUT)
//   - PAD_CODE_DFLT : default nibble shown in unused or blanked display digits
//   - BCD_NINE      : saturation digit used when the value does not fit
//   - ADD3_THRESH   : double-dabble correction threshold (digit >= 5 gets +3)
// ---------------------------------------------------------------------------
package meas_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    LOAD_OUT = 2'd2
  } fmt_state_t;

  localparam logic [3:0] PAD_CODE_DFLT = 4'hF;
  localparam logic [3:0] BCD_NINE      = 4'd9;
  localparam logic [3:0] ADD3_THRESH   = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//   Combinational double-dabble correction for one BCD digit: a digit of 5 or
//   more gets 3 added so that the following left shift carries correctly into
//   the next decimal digit.
// Ports
//   digit    in  4  current BCD digit (0..9)
//   adjusted out 4  digit after the conditional +3 (0..12)
// ---------------------------------------------------------------------------
module bcd_digit_adj
  import meas_fmt_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= ADD3_THRESH) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/meas_bcd_formatter.sv
// ---------------------------------------------------------------------------
// meas_bcd_formatter
//   Converts the binary measurement word into packed BCD nibbles for the
//   seven-segment display. Sequential double-dabble, one input bit per clock.
//
//   Handshake: BinValid is a one-cycle strobe sampled on a rising Clk edge.
//   A strobe in IDLE starts a conversion at once; a strobe at any other time
//   is parked in a one-deep pending register (last strobe wins) and started in
//   the IDLE cycle that follows LOAD_OUT. A strobe in that same IDLE cycle wins
//   over the pending value, which is then dropped. Busy is high during the
//   BIN_W shift cycles; Done pulses for one cycle when DigitsOut/Overflow take
//   the new result. DigitsOut only ever changes together with Done.
//
// Parameters
//   BIN_W    binary input width
//   DIGITS   BCD digits produced (values that need more saturate to 9s)
//   OUT_DIG  nibbles on DigitsOut; nibbles >= DIGITS carry PAD_CODE
//   PAD_CODE nibble used for unused and blanked digits
//
// Ports
//   Clk       in   1          system clock
//   Rst_n     in   1          asynchronous active-low reset
//   BinIn     in   BIN_W      value to convert
//   BinValid  in   1          strobe: BinIn valid this cycle
//   Busy      out  1          conversion shifting
//   Done      out  1          one-cycle pulse: outputs just updated
//   Overflow  out  1          last value needed more than DIGITS digits
//   DigitsOut out  4*OUT_DIG  packed BCD, units digit in [3:0]
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits above the units
//   digit are replaced by PAD_CODE when the result is loaded.
// ---------------------------------------------------------------------------
module meas_bcd_formatter
  import meas_fmt_pkg::*;
#(
  parameter int unsigned BIN_W    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned OUT_DIG  = 8,
  parameter logic [3:0]  PAD_CODE = PAD_CODE_DFLT
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [BIN_W-1:0]     BinIn,
  input  logic                 BinValid,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Overflow,
  output logic [4*OUT_DIG-1:0] DigitsOut
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (DIGITS > OUT_DIG) begin : g_bad_digits
    $error("meas_bcd_formatter: DIGITS must not exceed OUT_DIG");
  end
  if (BIN_W == 0) begin : g_bad_width
    $error("meas_bcd_formatter: BIN_W must be at least 1");
  end

  // Place the DIGITS converted nibbles at the bottom, pad everything above.
  function automatic logic [4*OUT_DIG-1:0] pad_upper(input logic [BCD_W-1:0] low);
    logic [4*OUT_DIG-1:0] r;
    r = '0;
    for (int i = 0; i < int'(OUT_DIG); i++) begin
      if (i < int'(DIGITS)) r[4*i +: 4] = low[4*i +: 4];
      else                  r[4*i +: 4] = PAD_CODE;
    end
    return r;
  endfunction

  localparam logic [4*OUT_DIG-1:0] RESET_DIGITS = pad_upper('0);

  fmt_state_t       state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] bit_cnt;
  logic             ovf_acc;
  logic             pend_valid;
  logic [BIN_W-1:0] pend_val;
  logic [BCD_W-1:0] low_digits;
  logic [BCD_W-1:0] shown_digits;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_sr[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  // A value that carried out of the top digit cannot be shown; show all 9s.
  assign low_digits = ovf_acc ? {DIGITS{BCD_NINE}} : bcd_sr;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; zeros stay blanked until the first non-zero
  // digit. The units digit is never blanked so a value of 0 shows as "0".
  logic lead;
  always_comb begin
    shown_digits = low_digits;
    lead         = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (low_digits[4*i +: 4] == 4'd0)) begin
        shown_digits[4*i +: 4] = PAD_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign shown_digits = low_digits;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      bit_cnt    <= '0;
      ovf_acc    <= 1'b0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Overflow   <= 1'b0;
      DigitsOut  <= RESET_DIGITS;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (BinValid || pend_valid) begin
            bin_sr     <= BinValid ? BinIn : pend_val;
            bcd_sr     <= '0;
            ovf_acc    <= 1'b0;
            bit_cnt    <= CNT_W'(BIN_W - 1);
            pend_valid <= 1'b0;
            Busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the corrected accumulator is the carry out of the
          // most significant digit; it is shifted away and remembered.
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          ovf_acc          <= ovf_acc | bcd_adj[BCD_W-1];
          if (bit_cnt == '0) begin
            Busy  <= 1'b0;
            state <= LOAD_OUT;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        LOAD_OUT: begin
          DigitsOut <= pad_upper(shown_digits);
          Overflow  <= ovf_acc;
          Done      <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Strobes outside IDLE are parked; IDLE consumes them directly.
      if (BinValid && (state != IDLE)) begin
        pend_valid <= 1'b1;
        pend_val   <= BinIn;
      end
    end
  end

endmodule

// File: tb/tb_meas_bcd_formatter.sv
module tb_meas_bcd_formatter;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] BinIn = '0;
  logic        BinValid = 1'b0;

  logic        Busy, Done, Overflow;
  logic [31:0] DigitsOut;
  logic        Busy4, Done4, Overflow4;
  logic [31:0] DigitsOut4;

  always #5 Clk = ~Clk;

  meas_bcd_formatter #(.BIN_W(16), .DIGITS(5), .OUT_DIG(8), .PAD_CODE(4'hF)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .BinIn(BinIn), .BinValid(BinValid),
    .Busy(Busy), .Done(Done), .Overflow(Overflow), .DigitsOut(DigitsOut)
  );

  // Four-digit build shares the stimulus; exercises the overflow path.
  meas_bcd_formatter #(.BIN_W(16), .DIGITS(4), .OUT_DIG(8), .PAD_CODE(4'hF)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .BinIn(BinIn), .BinValid(BinValid),
    .Busy(Busy4), .Done(Done4), .Overflow(Overflow4), .DigitsOut(DigitsOut4)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [31:0] E5_ZERO = 32'hFFFFFFF0, E4_ZERO = 32'hFFFFFFF0;
  localparam logic [31:0] E5_763  = 32'hFFFFF763, E4_763  = 32'hFFFFF763;
  localparam logic [31:0] E5_42   = 32'hFFFFFF42, E4_42   = 32'hFFFFFF42;
`else
  localparam logic [31:0] E5_ZERO = 32'hFFF00000, E4_ZERO = 32'hFFFF0000;
  localparam logic [31:0] E5_763  = 32'hFFF00763, E4_763  = 32'hFFFF0763;
  localparam logic [31:0] E5_42   = 32'hFFF00042, E4_42   = 32'hFFFF0042;
`endif

  // ---------------- scoreboard ----------------
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by division, pad above nd digits, 9s on overflow.
  function automatic logic [31:0] model(input int unsigned v, input int unsigned nd);
    logic [31:0] r;
    int unsigned x;
    r = 32'hFFFFFFFF;
    if (v >= 10 ** nd) begin
      for (int i = 0; i < int'(nd); i++) r[4*i +: 4] = 4'd9;
      return r;
    end
    x = v;
    for (int i = 0; i < int'(nd); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = int'(nd) - 1; i >= 1; i--) begin
      if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else break;
    end
`endif
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [15:0] v);
    @(negedge Clk);
    BinIn    = v;
    BinValid = 1'b1;
    @(negedge Clk);
    BinValid = 1'b0;
  endtask

  // Counts clocks until Done is seen (sampled 1 time unit after each edge)
  // and the samples on which Busy was high. Bounded.
  task automatic wait_done(input string tag, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (1) begin
      if (Busy) busy_cycles++;
      @(posedge Clk);
      #1;
      cycles++;
      if (Done) break;
      if (cycles >= 60) begin
        n_cmp++;
        n_fail++;
        $error("FAIL %s: no Done within 60 cycles", tag);
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (Done) seen++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, bsy, seen, last_done;
    logic [31:0] e;

    // reset state
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_digits", DigitsOut, 32'hFFF00000);
    check("rst_digits4", DigitsOut4, 32'hFFFF0000);
    check("rst_busy4", Busy4, 0);

    // 1: zero
    strobe(16'd0);
    wait_done("t1", lat, bsy);
    check("t1_latency", lat, 17);
    check("t1_digits", DigitsOut, E5_ZERO);
    check("t1_digits4", DigitsOut4, E4_ZERO);
    check("t1_done4", Done4, 1);
    @(posedge Clk); #1;
    check("t1_done_width", Done, 0);

    // 2: 763
    strobe(16'd763);
    wait_done("t2", lat, bsy);
    check("t2_latency", lat, 17);
    check("t2_busy_cycles", bsy, 16);
    check("t2_busy_after", Busy, 0);
    check("t2_digits", DigitsOut, E5_763);
    check("t2_ovf", Overflow, 0);
    check("t2_digits4", DigitsOut4, E4_763);

    // 4: pending, last strobe wins, 18-clock spacing
    strobe(16'd1234);
    repeat (3) @(negedge Clk);
    strobe(16'd5678);
    strobe(16'd4321);
    exp_q.push_back(model(1234, 5));
    exp_q.push_back(model(4321, 5));
    wait_done("t4a", lat, bsy);
    check("t4_first", DigitsOut, exp_q.pop_front());
    wait_done("t4b", lat, bsy);
    check("t4_spacing", lat, 18);
    check("t4_second", DigitsOut, exp_q.pop_front());
    check("t4_second4", DigitsOut4, model(4321, 4));
    count_done(25, seen);
    check("t4_no_extra_done", seen, 0);

    // 3: full scale, plus four-digit overflow
    strobe(16'd65535);
    wait_done("t3", lat, bsy);
    check("t3_digits", DigitsOut, 32'hFFF65535);
    check("t3_ovf", Overflow, 0);
    check("t3_digits4", DigitsOut4, 32'hFFFF9999);
    check("t3_ovf4", Overflow4, 1);

    // 5: reset mid-conversion
    strobe(16'd99);
    repeat (8) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("t5_busy", Busy, 0);
    check("t5_done", Done, 0);
    check("t5_digits", DigitsOut, 32'hFFF00000);
    check("t5_digits4", DigitsOut4, 32'hFFFF0000);
    check("t5_ovf4", Overflow4, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    count_done(25, seen);
    check("t5_no_done", seen, 0);
    strobe(16'd42);
    wait_done("t5b", lat, bsy);
    check("t5_after_42", DigitsOut, E5_42);
    check("t5_after_42_4", DigitsOut4, E4_42);
    check("t5_ovf4_cleared", Overflow4, 0);

    // 6: continuous strobes; service edges every 18 clocks
    for (int k = 0; k < 4; k++) exp_q.push_back(model(100 + 18 * k, 5));
    last_done = -1;
    for (int i = 0; i < 72; i++) begin
      @(negedge Clk);
      BinIn    = 16'(100 + i);
      BinValid = 1'b1;
      @(posedge Clk);
      #1;
      if (Done) begin
        if (exp_q.size() == 0) e = 32'hxxxxxxxx;
        else e = exp_q.pop_front();
        check("t6_value", DigitsOut, e);
        if (last_done >= 0) check("t6_spacing", i - last_done, 18);
        else check("t6_first_latency", i, 17);
        last_done = i;
      end
    end
    @(negedge Clk);
    BinValid = 1'b0;
    check("t6_all_seen", exp_q.size(), 0);
    // value 171 was parked during the last LOAD_OUT and is served on its own
    wait_done("t6_drain", lat, bsy);
    check("t6_drain_value", DigitsOut, model(171, 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
